kernel_stream_seq: RTL and testbench
====================================

KERNEL_STREAM_SEQ -- requirements
Module: kernel_stream_seq

Interface
REQ-001 The module SHALL have parameter STREAMW, default 32, stream data width.
REQ-002 The module SHALL have parameter CNTW, default 16, item-counter width.
REQ-003 The module SHALL have parameter MAXFLIGHT, default 8, maximum items inside the kernel at once (1..2^CNTW-1).
REQ-004 The module SHALL have one clock; reset is asynchronous and active-low; ports are named clk and rst.
REQ-005 clk  input  1  clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  launch request; sampled only in IDLE.
REQ-008 nitems  input  CNTW  item count for the run; captured when start is accepted.
REQ-009 busy  output  1  high in RUN and DRAIN.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 src_valid / src_ready / src_data  input / output / input  1 / 1 / STREAMW  upstream stream.
REQ-012 k_ivalid / k_iready / k_in  output / input / output  1 / 1 / STREAMW  kernel input side.
REQ-013 k_ovalid / k_oready / k_out  input / output / input  1 / 1 / STREAMW  kernel output side.
REQ-014 dst_valid / dst_ready / dst_data  output / input / output  1 / 1 / STREAMW  downstream stream.
REQ-015 in_count, out_count  output  CNTW  items issued / retired in the current or last run.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE->RUN on start=1 with nitems!=0; nitems is latched and in_count, out_count and the in-flight counter are cleared.
REQ-018 IDLE->DONE on start=1 with nitems==0; no stream transfer occurs.
REQ-019 RUN->DRAIN in the cycle after the input handshake that makes in_count equal the latched count.
REQ-020 RUN or DRAIN->DONE in the cycle after the output handshake that makes out_count equal the latched count; if the final input and final output handshakes coincide, RUN SHALL go directly to DONE.
REQ-021 DONE->IDLE unconditionally after one cycle; done SHALL be 1 exactly while in DONE.
REQ-022 start SHALL be ignored outside IDLE.
REQ-023 Issue gate: g_in = (state==RUN) & (in_count < latched count) & (inflight < MAXFLIGHT).
REQ-024 k_ivalid = src_valid & g_in, and src_ready = k_iready & g_in; both combinational, with zero added latency.
REQ-025 k_in SHALL equal src_data combinationally.
REQ-026 Retire gate: g_out = (state==RUN or DRAIN) & (inflight != 0).
REQ-027 dst_valid = k_ovalid & g_out, and k_oready = dst_ready & g_out; dst_data = k_out combinationally.
REQ-028 An input handshake (k_ivalid & k_iready) SHALL increment in_count and inflight; an output handshake (dst_valid & dst_ready) SHALL increment out_count and decrement inflight.
REQ-029 Simultaneous input and output handshakes SHALL leave inflight unchanged.
REQ-030 inflight SHALL never exceed MAXFLIGHT or go below 0, and counters SHALL never wrap within a run.
REQ-031 Kernel outputs offered while inflight==0 SHALL be back-pressured (k_oready=0) and not counted.
REQ-032 in_count and out_count SHALL hold their final values through DONE and IDLE until the next accepted start.

Reset
REQ-033 On rst=0 the FSM SHALL enter IDLE immediately; all counters and latched nitems SHALL become 0; busy and done SHALL be 0; all gated valid/ready outputs SHALL therefore be 0.
REQ-034 Reset asserted mid-run SHALL abort the run with no done pulse; after release, the block SHALL accept a new start.

Verification
REQ-035 Verify nitems=5 with src, kernel and dst always ready and a 3-cycle kernel latency -> 5 transfers each side, done pulses once, in_count=out_count=5.
REQ-036 Verify MAXFLIGHT=2, nitems=6, dst_ready=0 for 10 cycles -> src_ready falls after 2 issues, inflight holds 2, and the run completes once dst_ready=1.
REQ-037 Verify start with nitems=0 -> DONE the next cycle, done pulses for 1 cycle, busy stays 0, and no handshakes occur.
REQ-038 Verify a start pulse during RUN with nitems=3 -> it is ignored and the run ends after exactly 3 items.
REQ-039 Verify rst=0 after 2 of 4 items -> immediate IDLE with counters 0 and no done pulse; a subsequent start with nitems=4 completes normally.
REQ-040 Verify a spurious k_ovalid=1 in IDLE -> k_oready=0, dst_valid=0, and out_count is unchanged.

Source files
------------

// File: rtl/kernel_stream_seq.sv
// kernel_stream_seq: sequences a fixed-length run of items from an upstream
// stream through a pipelined kernel and on to a downstream stream. It gates
// both kernel handshakes and bounds the number of items inside the kernel.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; counters hold the results of the last run
// RUN    | issuing items into the kernel and retiring results
// DRAIN  | every item issued; retiring the remaining kernel results
// DONE   | one-cycle completion pulse, then back to IDLE
module kernel_stream_seq #(
    parameter int STREAMW   = 32,
    parameter int CNTW      = 16,
    parameter int MAXFLIGHT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNTW-1:0]    nitems,
    output logic               busy,
    output logic               done,
    input  logic               src_valid,
    output logic               src_ready,
    input  logic [STREAMW-1:0] src_data,
    output logic               k_ivalid,
    input  logic               k_iready,
    output logic [STREAMW-1:0] k_in,
    input  logic               k_ovalid,
    output logic               k_oready,
    input  logic [STREAMW-1:0] k_out,
    output logic               dst_valid,
    input  logic               dst_ready,
    output logic [STREAMW-1:0] dst_data,
    output logic [CNTW-1:0]    in_count,
    output logic [CNTW-1:0]    out_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNTW-1:0] MAXF = CNTW'(MAXFLIGHT);
    localparam logic [CNTW-1:0] ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] ZERO = '0;

    state_t          state_q, state_d;
    logic [CNTW-1:0] nitems_q, nitems_d;
    logic [CNTW-1:0] in_count_q, in_count_d;
    logic [CNTW-1:0] out_count_q, out_count_d;
    logic [CNTW-1:0] inflight_q, inflight_d;

    logic            g_in;
    logic            g_out;
    logic            in_hs;
    logic            out_hs;
    logic            in_last;
    logic            out_last;
    logic [CNTW-1:0] in_count_inc;
    logic [CNTW-1:0] out_count_inc;

    // Handshake gating between the streams and the kernel; purely combinational.
    always_comb begin
        g_in  = (state_q == ST_RUN) && (in_count_q < nitems_q) && (inflight_q < MAXF);
        g_out = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && (inflight_q != ZERO);

        k_ivalid  = src_valid & g_in;
        src_ready = k_iready & g_in;
        k_in      = src_data;

        dst_valid = k_ovalid & g_out;
        k_oready  = dst_ready & g_out;
        dst_data  = k_out;

        in_hs  = k_ivalid & k_iready;
        out_hs = dst_valid & dst_ready;

        in_count_inc  = in_count_q + ONE;
        out_count_inc = out_count_q + ONE;
        in_last       = in_hs && (in_count_inc == nitems_q);
        out_last      = out_hs && (out_count_inc == nitems_q);
    end

    // Next-state, counter and in-flight bookkeeping.
    always_comb begin
        state_d     = state_q;
        nitems_d    = nitems_q;
        in_count_d  = in_count_q;
        out_count_d = out_count_q;
        inflight_d  = inflight_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    nitems_d    = nitems;
                    in_count_d  = ZERO;
                    out_count_d = ZERO;
                    inflight_d  = ZERO;
                    state_d     = (nitems == ZERO) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (in_hs) begin
                    in_count_d = in_count_inc;
                end
                if (out_hs) begin
                    out_count_d = out_count_inc;
                end
                // Simultaneous issue and retire cancel out.
                if (in_hs && !out_hs) begin
                    inflight_d = inflight_q + ONE;
                end else if (!in_hs && out_hs) begin
                    inflight_d = inflight_q - ONE;
                end

                // Final retire can only coincide with final issue while in RUN,
                // in which case DRAIN is skipped.
                if (out_last) begin
                    state_d = ST_DONE;
                end else if ((state_q == ST_RUN) && in_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            nitems_q    <= '0;
            in_count_q  <= '0;
            out_count_q <= '0;
            inflight_q  <= '0;
        end else begin
            state_q     <= state_d;
            nitems_q    <= nitems_d;
            in_count_q  <= in_count_d;
            out_count_q <= out_count_d;
            inflight_q  <= inflight_d;
        end
    end

    // Status outputs decoded from registered state.
    always_comb begin
        busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        done      = (state_q == ST_DONE);
        in_count  = in_count_q;
        out_count = out_count_q;
    end

endmodule

// File: tb/tb_kernel_stream_seq.sv
// Directed bench for kernel_stream_seq with a behavioural fixed-latency kernel.
module tb_kernel_stream_seq;

    localparam int SW  = 16;
    localparam int CW  = 8;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] nitems = '0;
    logic          busy, done;
    logic          src_valid = 1'b0;
    logic          src_ready;
    logic [SW-1:0] src_data;
    logic          k_ivalid;
    logic          k_iready = 1'b1;
    logic [SW-1:0] k_in;
    logic          k_ovalid;
    logic          k_oready;
    logic [SW-1:0] k_out;
    logic          dst_valid;
    logic          dst_ready = 1'b0;
    logic [SW-1:0] dst_data;
    logic [CW-1:0] in_count, out_count;

    logic          spur_ov = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    kernel_stream_seq #(.STREAMW(SW), .CNTW(CW), .MAXFLIGHT(2)) dut (
        .clk(clk), .rst(rst), .start(start), .nitems(nitems),
        .busy(busy), .done(done),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .k_ivalid(k_ivalid), .k_iready(k_iready), .k_in(k_in),
        .k_ovalid(k_ovalid), .k_oready(k_oready), .k_out(k_out),
        .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_data(dst_data),
        .in_count(in_count), .out_count(out_count)
    );

    always #5 clk = ~clk;

    // Behavioural kernel: FIFO with a fixed latency from issue to result.
    logic [SW-1:0] kq_data [16];
    int            kq_time [16];
    logic [3:0]    kq_head, kq_tail;
    int            cyc;
    int            src_seq, exp_seq;

    assign src_data = SW'(32'h1000 + src_seq);
    assign k_ovalid = spur_ov | ((kq_head != kq_tail) && (cyc >= kq_time[kq_head]));
    assign k_out    = spur_ov ? 16'hDEAD : kq_data[kq_head];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            kq_head <= '0;
            kq_tail <= '0;
            cyc     <= 0;
            src_seq <= 0;
            exp_seq <= 0;
        end else begin
            cyc <= cyc + 1;
            if (k_ivalid && k_iready) begin
                kq_data[kq_tail] <= k_in;
                kq_time[kq_tail] <= cyc + LAT;
                kq_tail          <= kq_tail + 4'd1;
                src_seq          <= src_seq + 1;
            end
            if (k_ovalid && k_oready && !spur_ov) kq_head <= kq_head + 4'd1;
            if (dst_valid && dst_ready) exp_seq <= exp_seq + 1;
        end
    end

    // Event counters that survive resets; tests compare deltas.
    int in_hs_cnt = 0, out_hs_cnt = 0, done_cnt = 0, data_err = 0;
    always @(posedge clk) begin
        if (k_ivalid && k_iready) in_hs_cnt <= in_hs_cnt + 1;
        if (dst_valid && dst_ready) begin
            out_hs_cnt <= out_hs_cnt + 1;
            if (dst_data !== SW'(32'h1000 + exp_seq)) data_err <= data_err + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 200 && done !== 1'b1; i++) step();
        chk(tag, 32'(done), 32'd1);
    endtask

    int in0, out0, d0;

    initial begin
        src_valid = 1'b1;
        #12;
        // Reset state with upstream and downstream asserting.
        dst_ready = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_in_count", 32'(in_count), 0);
        chk("rst_out_count", 32'(out_count), 0);
        chk("rst_src_ready", 32'(src_ready), 0);
        chk("rst_k_ivalid", 32'(k_ivalid), 0);
        chk("rst_k_oready", 32'(k_oready), 0);
        step();
        rst = 1'b1;
        step();

        // 5 items, everything ready, kernel latency 3.
        in0 = in_hs_cnt; out0 = out_hs_cnt; d0 = done_cnt;
        start = 1'b1; nitems = 8'd5;
        step();
        start = 1'b0;
        chk("A_busy", 32'(busy), 1);
        wait_done("A_done_seen");
        chk("A_busy_in_done", 32'(busy), 0);
        chk("A_in_count", 32'(in_count), 5);
        chk("A_out_count", 32'(out_count), 5);
        chk("A_in_hs", 32'(in_hs_cnt - in0), 5);
        chk("A_out_hs", 32'(out_hs_cnt - out0), 5);
        step();
        chk("A_done_low", 32'(done), 0);
        chk("A_done_pulses", 32'(done_cnt - d0), 1);
        step();
        chk("A_in_count_hold", 32'(in_count), 5);

        // In-flight limit of 2 with downstream stalled.
        dst_ready = 1'b0;
        in0 = in_hs_cnt; out0 = out_hs_cnt; d0 = done_cnt;
        start = 1'b1; nitems = 8'd6;
        step();
        start = 1'b0;
        repeat (10) step();
        chk("B_in_count", 32'(in_count), 2);
        chk("B_in_hs", 32'(in_hs_cnt - in0), 2);
        chk("B_src_ready", 32'(src_ready), 0);
        chk("B_k_ivalid", 32'(k_ivalid), 0);
        chk("B_dst_valid", 32'(dst_valid), 1);
        chk("B_k_oready", 32'(k_oready), 0);
        chk("B_out_count", 32'(out_count), 0);
        dst_ready = 1'b1;
        wait_done("B_done_seen");
        chk("B_in_count_end", 32'(in_count), 6);
        chk("B_out_count_end", 32'(out_count), 6);
        chk("B_out_hs", 32'(out_hs_cnt - out0), 6);
        step();
        chk("B_done_pulses", 32'(done_cnt - d0), 1);

        // Zero-length run.
        in0 = in_hs_cnt; out0 = out_hs_cnt; d0 = done_cnt;
        start = 1'b1; nitems = 8'd0;
        step();
        start = 1'b0;
        chk("C_done", 32'(done), 1);
        chk("C_busy", 32'(busy), 0);
        chk("C_src_ready", 32'(src_ready), 0);
        step();
        chk("C_done_low", 32'(done), 0);
        chk("C_busy_after", 32'(busy), 0);
        chk("C_done_pulses", 32'(done_cnt - d0), 1);
        chk("C_no_in_hs", 32'(in_hs_cnt - in0), 0);
        chk("C_no_out_hs", 32'(out_hs_cnt - out0), 0);

        // Start pulse during RUN is ignored.
        in0 = in_hs_cnt; out0 = out_hs_cnt; d0 = done_cnt;
        start = 1'b1; nitems = 8'd3;
        step();
        start = 1'b0;
        step();
        start = 1'b1; nitems = 8'd7;
        step();
        start = 1'b0;
        wait_done("D_done_seen");
        chk("D_in_count", 32'(in_count), 3);
        chk("D_out_count", 32'(out_count), 3);
        chk("D_in_hs", 32'(in_hs_cnt - in0), 3);
        step();
        chk("D_done_pulses", 32'(done_cnt - d0), 1);
        chk("D_idle_busy", 32'(busy), 0);

        // Reset in the middle of a run.
        d0 = done_cnt;
        start = 1'b1; nitems = 8'd4;
        step();
        start = 1'b0;
        for (int i = 0; i < 20 && in_count !== 8'd2; i++) step();
        chk("E_reached_2", 32'(in_count), 2);
        rst = 1'b0;
        #1;
        chk("E_rst_busy", 32'(busy), 0);
        chk("E_rst_in_count", 32'(in_count), 0);
        chk("E_rst_out_count", 32'(out_count), 0);
        chk("E_rst_src_ready", 32'(src_ready), 0);
        chk("E_rst_dst_valid", 32'(dst_valid), 0);
        repeat (3) step();
        chk("E_no_done", 32'(done_cnt - d0), 0);
        rst = 1'b1;
        step();
        in0 = in_hs_cnt; out0 = out_hs_cnt; d0 = done_cnt;
        start = 1'b1; nitems = 8'd4;
        step();
        start = 1'b0;
        wait_done("E_done_seen");
        chk("E_in_count", 32'(in_count), 4);
        chk("E_out_count", 32'(out_count), 4);
        chk("E_out_hs", 32'(out_hs_cnt - out0), 4);
        step();
        chk("E_done_pulses", 32'(done_cnt - d0), 1);

        // Spurious kernel output while idle.
        out0 = out_hs_cnt;
        spur_ov = 1'b1;
        #1;
        chk("F_k_oready", 32'(k_oready), 0);
        chk("F_dst_valid", 32'(dst_valid), 0);
        step();
        step();
        chk("F_out_count", 32'(out_count), 4);
        chk("F_out_hs", 32'(out_hs_cnt - out0), 0);
        spur_ov = 1'b0;

        chk("data_order", 32'(data_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
